// File: rtl/kmp_pkg.sv
// Shared state encoding for the KMP search engine; the state code is exported on actual_state.
package kmp_pkg;

  localparam int ST_W = 4;

  typedef enum logic [ST_W-1:0] {
    ST_IDLE    = 4'd0,
    ST_LOAD_RD = 4'd1,
    ST_LOAD_WR = 4'd2,
    ST_BUILD   = 4'd3,
    ST_TXT_RD  = 4'd4,
    ST_TXT_CMP = 4'd5,
    ST_DONE    = 4'd6
  } kmp_state_t;

endpackage

// File: rtl/kmp_prefix_builder.sv
// Builds the KMP failure table one step per cycle after a go pulse.
// ready is a single-cycle pulse once i reaches pat_len; the table then holds until the next go.
module kmp_prefix_builder #(
  parameter int CHAR_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int PAT_AW  = $clog2(PAT_MAX)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       go,
  input  logic [PAT_AW:0]            pat_len,
  input  logic [PAT_MAX*CHAR_W-1:0]  pat_flat,
  output logic [PAT_MAX*PAT_AW-1:0]  fail_flat,
  output logic                       ready
);

  logic [CHAR_W-1:0] pat_a  [PAT_MAX];
  logic [PAT_AW-1:0] fail_q [PAT_MAX];
  logic [PAT_AW-1:0] fail_d [PAT_MAX];
  logic [PAT_AW:0]   i_q, i_d;
  logic [PAT_AW-1:0] k_q, k_d;
  logic              run_q, run_d;
  logic [PAT_AW-1:0] i_idx;

  for (genvar g = 0; g < PAT_MAX; g++) begin : g_unpack
    assign pat_a[g] = pat_flat[g*CHAR_W +: CHAR_W];
    assign fail_flat[g*PAT_AW +: PAT_AW] = fail_q[g];
  end

  // i never indexes the table once it equals pat_len, so the low bits suffice.
  assign i_idx = i_q[PAT_AW-1:0];
  assign ready = run_q && (i_q == pat_len);

  always_comb begin
    fail_d = fail_q;
    i_d    = i_q;
    k_d    = k_q;
    run_d  = run_q;
    if (go) begin
      for (int n = 0; n < PAT_MAX; n++) fail_d[n] = '0;
      i_d   = {{PAT_AW{1'b0}}, 1'b1};
      k_d   = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      if (i_q == pat_len) begin
        run_d = 1'b0;
      end else if (pat_a[i_idx] == pat_a[k_q]) begin
        fail_d[i_idx] = k_q + 1'b1;
        k_d           = k_q + 1'b1;
        i_d           = i_q + 1'b1;
      end else if (k_q != '0) begin
        k_d = fail_q[k_q - 1'b1];
      end else begin
        fail_d[i_idx] = '0;
        i_d           = i_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < PAT_MAX; n++) fail_q[n] <= '0;
      i_q   <= '0;
      k_q   <= '0;
      run_q <= 1'b0;
    end else begin
      fail_q <= fail_d;
      i_q    <= i_d;
      k_q    <= k_d;
      run_q  <= run_d;
    end
  end

endmodule

// File: rtl/kmp_search_param.sv
// KMP search: loads a pattern from a sync ROM, builds its failure table, scans a sync text ROM.
// Load costs 2 cycles/char, scan 2 cycles/char plus one per fallback; start is ignored while busy.
module kmp_search_param #(
  parameter int CHAR_W  = 8,
  parameter int PAT_MAX = 8,
  parameter int PAT_AW  = $clog2(PAT_MAX),
  parameter int TXT_AW  = 14,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              overlap,
  input  logic [PAT_AW:0]   pat_len,
  input  logic [TXT_AW:0]   txt_len,
  output logic [PAT_AW-1:0] pat_addr,
  input  logic [CHAR_W-1:0] pat_data,
  output logic [TXT_AW-1:0] txt_addr,
  input  logic [CHAR_W-1:0] txt_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              match,
  output logic [CNT_W-1:0]  match_count,
  output logic [TXT_AW-1:0] last_pos,
  output logic [3:0]        actual_state
);
  import kmp_pkg::*;

  localparam logic [PAT_AW:0] PMAX = PAT_MAX[PAT_AW:0];

  kmp_state_t        state_q, state_d;
  logic [PAT_AW-1:0] j_q, j_d;
  logic [TXT_AW-1:0] t_q, t_d;
  logic [PAT_AW-1:0] q_q, q_d;
  logic              ovl_q, ovl_d;
  logic [PAT_AW:0]   plen_q, plen_d;
  logic [TXT_AW:0]   tlen_q, tlen_d;
  logic [CHAR_W-1:0] pat_q [PAT_MAX];
  logic [CHAR_W-1:0] pat_d [PAT_MAX];
  logic              err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [TXT_AW-1:0] last_q, last_d;
  logic              match_q, match_d;
  logic              build_go, build_rdy, adv;

  logic [PAT_MAX*CHAR_W-1:0] pat_flat;
  logic [PAT_MAX*PAT_AW-1:0] fail_flat;
  logic [PAT_AW-1:0]         fail_a [PAT_MAX];
  logic [TXT_AW:0]           pat_len_x;
  logic [TXT_AW-1:0]         plen_t;
  logic [PAT_AW:0]           plen_m1;
  logic                      hit;

  for (genvar g = 0; g < PAT_MAX; g++) begin : g_pack
    assign pat_flat[g*CHAR_W +: CHAR_W] = pat_q[g];
    assign fail_a[g] = fail_flat[g*PAT_AW +: PAT_AW];
  end

  assign pat_len_x = {{(TXT_AW-PAT_AW){1'b0}}, pat_len};
  assign plen_t    = {{(TXT_AW-PAT_AW-1){1'b0}}, plen_q};
  assign plen_m1   = plen_q - 1'b1;
  assign hit       = (txt_data == pat_q[q_q]);

  kmp_prefix_builder #(
    .CHAR_W (CHAR_W),
    .PAT_MAX(PAT_MAX),
    .PAT_AW (PAT_AW)
  ) u_pb (
    .clk      (clk),
    .rst      (rst),
    .go       (build_go),
    .pat_len  (plen_q),
    .pat_flat (pat_flat),
    .fail_flat(fail_flat),
    .ready    (build_rdy)
  );

  always_comb begin
    state_d  = state_q;
    j_d      = j_q;
    t_d      = t_q;
    q_d      = q_q;
    ovl_d    = ovl_q;
    plen_d   = plen_q;
    tlen_d   = tlen_q;
    pat_d    = pat_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    last_d   = last_q;
    match_d  = 1'b0;
    build_go = 1'b0;
    adv      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          ovl_d  = overlap;
          plen_d = pat_len;
          tlen_d = txt_len;
          cnt_d  = '0;
          last_d = '0;
          err_d  = 1'b0;
          j_d    = '0;
          t_d    = '0;
          q_d    = '0;
          if (pat_len == '0 || pat_len > PMAX || pat_len_x > txt_len) begin
            err_d   = 1'b1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_LOAD_RD;
          end
        end
      end
      ST_LOAD_RD: state_d = ST_LOAD_WR;
      ST_LOAD_WR: begin
        pat_d[j_q] = pat_data;
        if ({1'b0, j_q} == plen_m1) begin
          build_go = 1'b1;
          state_d  = ST_BUILD;
        end else begin
          j_d     = j_q + 1'b1;
          state_d = ST_LOAD_RD;
        end
      end
      ST_BUILD: begin
        if (build_rdy) begin
          t_d     = '0;
          q_d     = '0;
          state_d = ST_TXT_RD;
        end
      end
      ST_TXT_RD: state_d = ST_TXT_CMP;
      ST_TXT_CMP: begin
        // A fallback keeps the text address, so the ROM output is still valid next cycle.
        if (hit) begin
          adv = 1'b1;
          if ({1'b0, q_q} == plen_m1) begin
            match_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            last_d = t_q - plen_t + 1'b1;
            q_d    = ovl_q ? fail_a[plen_m1[PAT_AW-1:0]] : '0;
          end else begin
            q_d = q_q + 1'b1;
          end
        end else if (q_q != '0) begin
          q_d = fail_a[q_q - 1'b1];
        end else begin
          adv = 1'b1;
        end
        if (adv) begin
          if ({1'b0, t_q} == tlen_q - 1'b1) begin
            state_d = ST_DONE;
          end else begin
            t_d     = t_q + 1'b1;
            state_d = ST_TXT_RD;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      j_q     <= '0;
      t_q     <= '0;
      q_q     <= '0;
      ovl_q   <= 1'b0;
      plen_q  <= '0;
      tlen_q  <= '0;
      for (int n = 0; n < PAT_MAX; n++) pat_q[n] <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      last_q  <= '0;
      match_q <= 1'b0;
    end else begin
      state_q <= state_d;
      j_q     <= j_d;
      t_q     <= t_d;
      q_q     <= q_d;
      ovl_q   <= ovl_d;
      plen_q  <= plen_d;
      tlen_q  <= tlen_d;
      pat_q   <= pat_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      match_q <= match_d;
    end
  end

  assign pat_addr     = j_q;
  assign txt_addr     = t_q;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign err          = err_q;
  assign match        = match_q;
  assign match_count  = cnt_q;
  assign last_pos     = last_q;
  assign actual_state = state_q;

endmodule

// File: tb/tb_kmp_search_param.sv
// Randomised and directed bench for kmp_search_param against a brute-force substring search model.
module tb_kmp_search_param;

  localparam int CHAR_W  = 8;
  localparam int PAT_MAX = 8;
  localparam int PAT_AW  = 3;
  localparam int TXT_AW  = 6;
  localparam int CNT_W   = 2;
  localparam int TXT_N   = 1 << TXT_AW;
  localparam int BUDGET  = 2000;

  logic              clk, rst, start, overlap;
  logic [PAT_AW:0]   pat_len;
  logic [TXT_AW:0]   txt_len;
  logic [PAT_AW-1:0] pat_addr;
  logic [CHAR_W-1:0] pat_data;
  logic [TXT_AW-1:0] txt_addr;
  logic [CHAR_W-1:0] txt_data;
  logic              busy, done, err, match;
  logic [CNT_W-1:0]  match_count;
  logic [TXT_AW-1:0] last_pos;
  logic [3:0]        actual_state;

  logic [CHAR_W-1:0] pat_mem [PAT_MAX];
  logic [CHAR_W-1:0] txt_mem [TXT_N];

  int checks;
  int failures;

  kmp_search_param #(
    .CHAR_W(CHAR_W), .PAT_MAX(PAT_MAX), .PAT_AW(PAT_AW), .TXT_AW(TXT_AW), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .overlap(overlap),
    .pat_len(pat_len), .txt_len(txt_len),
    .pat_addr(pat_addr), .pat_data(pat_data),
    .txt_addr(txt_addr), .txt_data(txt_data),
    .busy(busy), .done(done), .err(err), .match(match),
    .match_count(match_count), .last_pos(last_pos), .actual_state(actual_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROMs: one-cycle read latency.
  always @(posedge clk) begin
    pat_data <= pat_mem[pat_addr];
    txt_data <= txt_mem[txt_addr];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic set_pat(input string s);
    for (int i = 0; i < PAT_MAX; i++) pat_mem[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  task automatic set_txt(input string s);
    for (int i = 0; i < TXT_N; i++) txt_mem[i] = (i < s.len()) ? s[i] : 8'h00;
  endtask

  // Longest proper prefix of pat[0..k] that is also its suffix.
  function automatic int border(input int k);
    int best;
    bit ok;
    best = 0;
    for (int l = 1; l <= k; l++) begin
      ok = 1'b1;
      for (int x = 0; x < l; x++)
        if (pat_mem[x] != pat_mem[k-l+1+x]) ok = 1'b0;
      if (ok) best = l;
    end
    return best;
  endfunction

  task automatic model(input int plen, input int tlen, input bit ovl,
                       output int cnt, output int last, output bit merr, output int nmatch);
    int  next;
    bit  hitp;
    merr   = (plen == 0) || (plen > PAT_MAX) || (plen > tlen);
    cnt    = 0;
    last   = 0;
    nmatch = 0;
    next   = 0;
    if (!merr) begin
      for (int p = 0; p + plen <= tlen; p++) begin
        hitp = 1'b1;
        for (int k = 0; k < plen; k++)
          if (txt_mem[p+k] != pat_mem[k]) hitp = 1'b0;
        if (hitp && (ovl || p >= next)) begin
          nmatch++;
          last = p;
          next = p + plen;
        end
      end
    end
    cnt = (nmatch > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : nmatch;
  endtask

  task automatic run_search(input string tag, input int plen, input int tlen,
                            input bit ovl, input bit poke_start);
    int e_cnt, e_last, e_n, cyc, pulses;
    bit e_err;
    model(plen, tlen, ovl, e_cnt, e_last, e_err, e_n);
    @(negedge clk);
    overlap = ovl;
    pat_len = plen[PAT_AW:0];
    txt_len = tlen[TXT_AW:0];
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, ".busy"}, busy, 1);
    cyc    = 0;
    pulses = 0;
    while (cyc < BUDGET) begin
      if (match) pulses++;
      if (done) break;
      start = poke_start && (cyc % 3 == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    chk({tag, ".in_budget"}, cyc < BUDGET, 1);
    chk({tag, ".err"}, err, e_err);
    chk({tag, ".cnt"}, match_count, e_cnt);
    chk({tag, ".last"}, last_pos, e_last);
    chk({tag, ".pulses"}, pulses, e_n);
    if (!e_err)
      for (int i = 0; i < plen; i++)
        chk($sformatf("%s.fail%0d", tag, i), dut.fail_flat[i*PAT_AW +: PAT_AW], border(i));
    @(negedge clk);
    chk({tag, ".done_once"}, done, 0);
    chk({tag, ".idle"}, busy, 0);
    chk({tag, ".cnt_hold"}, match_count, e_cnt);
  endtask

  initial begin
    int w;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    overlap  = 1'b0;
    pat_len  = '0;
    txt_len  = '0;
    set_pat("");
    set_txt("");
    repeat (3) @(negedge clk);
    chk("rst.state", actual_state, 0);
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.err", err, 0);
    chk("rst.cnt", match_count, 0);
    chk("rst.addr", {pat_addr, txt_addr}, 0);
    rst = 1'b0;

    set_pat("ABAB"); set_txt("ABABAB");
    run_search("ovl_on", 4, 6, 1'b1, 1'b0);
    chk("ovl_on.cnt_c", match_count, 2);
    chk("ovl_on.last_c", last_pos, 2);
    run_search("ovl_off", 4, 6, 1'b0, 1'b0);
    chk("ovl_off.cnt_c", match_count, 1);
    chk("ovl_off.last_c", last_pos, 0);

    set_pat("AAB"); set_txt("AAAAB");
    run_search("fallback", 3, 5, 1'b1, 1'b0);
    chk("fallback.last_c", last_pos, 2);
    chk("fallback.f1_c", dut.fail_flat[1*PAT_AW +: PAT_AW], 1);

    run_search("len0", 0, 5, 1'b1, 1'b0);
    chk("len0.err_c", err, 1);
    run_search("pat_gt_txt", 5, 3, 1'b1, 1'b0);
    chk("pat_gt_txt.err_c", err, 1);
    run_search("pat_gt_max", 9, 20, 1'b0, 1'b0);

    set_pat("A"); set_txt("AAAAA");
    run_search("sat", 1, 5, 1'b1, 1'b0);
    chk("sat.cnt_c", match_count, 3);
    chk("sat.last_c", last_pos, 4);

    set_pat("ABAB"); set_txt("ABABBABABAABABABBBAB");
    run_search("busy_start", 4, 20, 1'b1, 1'b1);

    // Reset in the middle of a scan.
    set_pat("AB"); set_txt({32{"AB"}});
    @(negedge clk);
    overlap = 1'b0; pat_len = 2; txt_len = 64; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    w = 0;
    while (!(actual_state == 4'd5 && match_count != 0) && w < BUDGET) begin
      @(negedge clk);
      w++;
    end
    chk("midrst.reach", w < BUDGET, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.state", actual_state, 0);
    chk("midrst.outs", {busy, done, err, match}, 0);
    chk("midrst.cnt", match_count, 0);
    chk("midrst.last", last_pos, 0);
    chk("midrst.addr", {pat_addr, txt_addr}, 0);
    // start together with rst: reset wins.
    start = 1'b1;
    @(negedge clk);
    chk("rst_start.state", actual_state, 0);
    rst = 1'b0; start = 1'b0;
    @(negedge clk);
    chk("rst_start.idle", actual_state, 0);

    for (int it = 0; it < 40; it++) begin
      int plen, tlen;
      bit ovl;
      plen = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(1, 4));
      tlen = $urandom_range(1, TXT_N);
      ovl  = 1'($urandom_range(0, 1));
      for (int x = 0; x < PAT_MAX; x++) pat_mem[x] = 8'($urandom_range(65, 66));
      for (int x = 0; x < TXT_N; x++) txt_mem[x] = 8'($urandom_range(65, 66));
      run_search($sformatf("rnd%0d", it), plen, tlen, ovl, (it % 4) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
